axi_rr_burst_arbiter: RTL
=========================

# axi_rr_burst_arbiter

Parametrised N-master bridge from the CPU-side SRAM-like bus (req/addr_ok/data_ok) to one AXI3 master port. It is the successor to the fixed two-port CPU-to-AXI interface, replacing its fixed instruction/data pairing with N round-robin-arbitrated masters (I-cache, D-cache, uncached path, …) and cache-line read bursts. It sits between the cache/bridge layer and the top-level AXI pins. The top level ties off the AXI signals this block does not drive: burst=INCR, lock/cache/prot=0, wlast=1, awid/wid=0.

## Interface
- N_MASTERS, 2: number of SRAM-like masters; 2..8.
- LINE_WORDS, 8: beats per burst read; power of two, 2..16.
- aclk  in  1  clock, rising edge.
- aresetn  in  1  asynchronous, active-low reset.
- m_req  in  N  per-master request.
- m_wr  in  N  1 = write.
- m_burst  in  N  1 = line read of LINE_WORDS words; ignored when m_wr=1.
- m_size  in  2N  0 = byte, 1 = half, 2 = word.
- m_addr  in  32N  byte address.
- m_wdata  in  32N  write data, byte-lane aligned.
- m_addr_ok  out  N  request accepted; one-hot or zero.
- m_data_ok  out  N  read beat valid / write response; one-hot or zero.
- m_last  out  1  qualifies m_data_ok: final beat.
- m_rdata  out  32  read data, shared by all masters.
- arid  out  4  granted master index.
- araddr, arlen, arsize  out  32, 8, 3  AR payload.
- arvalid / arready  out / in  1  AR handshake.
- rdata  in  32  read data.
- rlast, rvalid  in  1  R beat qualifiers; rresp and rid are ignored.
- rready  out  1  R accept.
- awaddr, awsize  out  32, 3  AW payload.
- awvalid / awready  out / in  1  AW handshake.
- wdata, wstrb  out  32, 4  W payload.
- wvalid / wready  out / in  1  W handshake.
- bvalid / bready  in / out  1  B handshake.

## Operation
- States: IDLE, AR, R, AW_W, B. Only one transaction is outstanding at a time.
- IDLE, arbitration:
  - The winner is the first m_req set, searching from ptr+1 upward and wrapping at N_MASTERS.
  - The winner's m_addr_ok is asserted combinationally in the same cycle.
  - ptr, index, wr, burst, size, addr and wdata are latched.
  - Next state is AR for a read, AW_W for a write.
- AR:
  - arvalid=1; arid=index.
  - Burst read: araddr = addr with its low log2(LINE_WORDS*4) bits cleared; arlen = LINE_WORDS-1; arsize=2.
  - Single read: araddr = addr; arlen=0; arsize=size.
  - On arready, go to R.
- R:
  - rready=1.
  - Each rvalid cycle: m_data_ok[index]=1, m_rdata=rdata, m_last=rlast.
  - rvalid & rlast returns to IDLE.
- AW_W:
  - awvalid and wvalid are raised together. Each drops independently after its own handshake; a sticky done-flag is kept per channel.
  - Both done, including in the same cycle, goes to B.
  - wstrb: size 0 gives 0001<<addr[1:0]; size 1 gives 0011<<{addr[1],0}; size 2 gives 1111.
  - awsize=size.
- B:
  - bready=1.
  - On bvalid: m_data_ok[index]=1, m_last=1, then IDLE.
- Outside the cycles above, m_addr_ok, m_data_ok and m_last are 0. m_rdata holds the last rdata.
- A request arriving in a non-IDLE state waits; masters hold req/payload until addr_ok.

## Timing
- Reset values: state IDLE, ptr=N_MASTERS-1 (master 0 wins first), all valid/ready/ok outputs 0, m_rdata 0, latched payload 0.
- Reset mid-transaction abandons it immediately. The AXI slave shares aresetn.
- Read, zero-wait slave:
  - cycle 0: req and addr_ok.
  - cycle 1: arvalid and arready.
  - cycle 2: first data_ok.
  - Burst: final beat at cycle 2+LINE_WORDS-1.
- Write, zero-wait slave: addr_ok at 0, aw/w handshakes at 1, data_ok at 2.
- Exactly one IDLE cycle separates consecutive transactions. All AXI outputs are registered or state-decoded; none depends combinationally on AXI inputs except m_data_ok, m_last and m_rdata (from rvalid/rlast/rdata/bvalid).
- Simultaneous requests are served strictly round-robin. No master waits more than N_MASTERS-1 transactions.

## Test plan
- Reset with all req=1, N=2 -> master 0 gets addr_ok first, then master 1, then master 0; arid sequence 0, 1, 0.
- Burst read from master 1, addr 0x1FC0_0014, LINE_WORDS=8 -> araddr 0x1FC0_0000, arlen 7, arsize 2. Eight data_ok[1] pulses; m_last only on the 8th. rdata is forwarded unmodified.
- Byte write, addr 0xBFAF_8003, with awready delayed 3 cycles and wready immediate -> wvalid drops after 1 cycle, awvalid held for 4 cycles, wstrb 1000. data_ok after bvalid.
- Halfword write, addr 0x...02 -> wstrb 1100, awsize 1. With awready and wready in the same cycle -> B state on the next cycle.
- Assert aresetn=0 during beat 3 of a burst -> next edge-free cycle shows arvalid/rready/m_data_ok=0 and state IDLE. After release, a new request is accepted normally.
- N_MASTERS=4, masters 1 and 3 requesting continuously -> grants alternate 1, 3, 1, 3. An idle master 2 that requests gets served within 2 transactions.

Source files
------------

// File: rtl/axi_rr_burst_arbiter.sv
// Round-robin bridge from N SRAM-like masters onto a single AXI3 master port.
// One transaction in flight; reads may be cache-line INCR bursts.
module axi_rr_burst_arbiter #(
  parameter int unsigned N_MASTERS  = 2,
  parameter int unsigned LINE_WORDS = 8
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic [N_MASTERS-1:0]   m_req,
  input  logic [N_MASTERS-1:0]   m_wr,
  input  logic [N_MASTERS-1:0]   m_burst,
  input  logic [2*N_MASTERS-1:0] m_size,
  input  logic [32*N_MASTERS-1:0] m_addr,
  input  logic [32*N_MASTERS-1:0] m_wdata,
  output logic [N_MASTERS-1:0]   m_addr_ok,
  output logic [N_MASTERS-1:0]   m_data_ok,
  output logic                   m_last,
  output logic [31:0]            m_rdata,
  output logic [3:0]             arid,
  output logic [31:0]            araddr,
  output logic [7:0]             arlen,
  output logic [2:0]             arsize,
  output logic                   arvalid,
  input  logic                   arready,
  input  logic [31:0]            rdata,
  input  logic                   rlast,
  input  logic                   rvalid,
  output logic                   rready,
  output logic [31:0]            awaddr,
  output logic [2:0]             awsize,
  output logic                   awvalid,
  input  logic                   awready,
  output logic [31:0]            wdata,
  output logic [3:0]             wstrb,
  output logic                   wvalid,
  input  logic                   wready,
  input  logic                   bvalid,
  output logic                   bready
);

  localparam int unsigned IdxW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
  localparam int unsigned SumW = IdxW + 2;
  localparam logic [31:0] LineMask = ~(32'(LINE_WORDS * 4) - 32'd1);

  typedef enum logic [2:0] {StIdle, StAr, StR, StAwW, StB} state_e;

  state_e          state_q, state_d;
  logic [IdxW-1:0] ptr_q, ptr_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic            burst_q, burst_d;
  logic [1:0]      size_q, size_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            aw_done_q, aw_done_d;
  logic            w_done_q, w_done_d;

  logic [2*N_MASTERS-1:0] req_dbl;
  logic [N_MASTERS-1:0]   req_rot;
  logic                   grant_valid;
  logic [IdxW-1:0]        grant_off;
  logic [IdxW-1:0]        grant_idx;
  logic [SumW-1:0]        grant_sum;

  // Rotate requests so bit 0 is master ptr+1; the lowest set bit wins.
  always_comb begin
    req_dbl     = {m_req, m_req};
    req_rot     = N_MASTERS'(req_dbl >> ({1'b0, ptr_q} + 1'b1));
    grant_valid = 1'b0;
    grant_off   = '0;
    for (int i = int'(N_MASTERS) - 1; i >= 0; i--) begin
      if (req_rot[i]) begin
        grant_valid = 1'b1;
        grant_off   = IdxW'(i);
      end
    end
    grant_sum = SumW'(ptr_q) + SumW'(grant_off) + SumW'(1);
    if (grant_sum >= SumW'(N_MASTERS)) begin
      grant_sum = grant_sum - SumW'(N_MASTERS);
    end
    grant_idx = IdxW'(grant_sum);
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    idx_d     = idx_q;
    burst_d   = burst_q;
    size_d    = size_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    m_addr_ok = '0;
    m_data_ok = '0;
    m_last    = 1'b0;
    m_rdata   = rdata_q;
    arvalid   = 1'b0;
    rready    = 1'b0;
    awvalid   = 1'b0;
    wvalid    = 1'b0;
    bready    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (grant_valid) begin
          m_addr_ok = N_MASTERS'(1) << grant_idx;
          ptr_d     = grant_idx;
          idx_d     = grant_idx;
          burst_d   = m_burst[grant_idx] & ~m_wr[grant_idx];
          size_d    = m_size[2*grant_idx +: 2];
          addr_d    = m_addr[32*grant_idx +: 32];
          wdata_d   = m_wdata[32*grant_idx +: 32];
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = m_wr[grant_idx] ? StAwW : StAr;
        end
      end
      StAr: begin
        arvalid = 1'b1;
        if (arready) state_d = StR;
      end
      StR: begin
        rready = 1'b1;
        if (rvalid) begin
          m_data_ok = N_MASTERS'(1) << idx_q;
          m_rdata   = rdata;
          m_last    = rlast;
          rdata_d   = rdata;
          if (rlast) state_d = StIdle;
        end
      end
      StAwW: begin
        // AW and W complete independently; sticky flags remember each handshake.
        awvalid   = ~aw_done_q;
        wvalid    = ~w_done_q;
        aw_done_d = aw_done_q | (awvalid & awready);
        w_done_d  = w_done_q | (wvalid & wready);
        if (aw_done_d && w_done_d) state_d = StB;
      end
      StB: begin
        bready = 1'b1;
        if (bvalid) begin
          m_data_ok = N_MASTERS'(1) << idx_q;
          m_last    = 1'b1;
          state_d   = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q   <= StIdle;
      ptr_q     <= IdxW'(N_MASTERS - 1);
      idx_q     <= '0;
      burst_q   <= 1'b0;
      size_q    <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      idx_q     <= idx_d;
      burst_q   <= burst_d;
      size_q    <= size_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  assign arid   = 4'(idx_q);
  assign araddr = burst_q ? (addr_q & LineMask) : addr_q;
  assign arlen  = burst_q ? 8'(LINE_WORDS - 1) : 8'd0;
  assign arsize = burst_q ? 3'd2 : {1'b0, size_q};
  assign awaddr = addr_q;
  assign awsize = {1'b0, size_q};
  assign wdata  = wdata_q;

  always_comb begin
    case (size_q)
      2'd0:    wstrb = 4'b0001 << addr_q[1:0];
      2'd1:    wstrb = 4'b0011 << {addr_q[1], 1'b0};
      default: wstrb = 4'b1111;
    endcase
  end

endmodule
